// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU-op, function and ALU select codes
package alu_pkg;

    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    localparam logic [5:0] FN_02 = 6'b000010;
    localparam logic [5:0] FN_03 = 6'b000011;
    localparam logic [5:0] FN_04 = 6'b000100;
    localparam logic [5:0] FN_05 = 6'b000101;
    localparam logic [5:0] FN_07 = 6'b000111;

    localparam logic [2:0] ALU_000 = 3'b000;
    localparam logic [2:0] ALU_001 = 3'b001;
    localparam logic [2:0] ALU_010 = 3'b010;
    localparam logic [2:0] ALU_011 = 3'b011;
    localparam logic [2:0] ALU_100 = 3'b100;
    localparam logic [2:0] ALU_101 = 3'b101;
    localparam logic [2:0] ALU_110 = 3'b110;

endpackage

// File: rtl/alu_funct_decode.sv
// rtl/alu_funct_decode.sv - combinational ALU-op / function field decode
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [5:0] F,
    input  logic [2:0] P,
    output logic [2:0] c_next,
    output logic       illegal_next
);

    always_comb begin
        c_next       = ALU_000;
        illegal_next = 1'b0;
        if (P != ALUOP_RTYPE) begin
            c_next = P;
        end else begin
            // Full 6-bit compare so any nonzero F[5:3] lands in default.
            case (F)
                FN_02:   c_next = ALU_101;
                FN_03:   c_next = ALU_110;
                FN_04:   c_next = ALU_000;
                FN_05:   c_next = ALU_001;
                FN_07:   c_next = ALU_100;
                default: begin
                    c_next       = ALU_000;
                    illegal_next = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - ALU control decoder with registered outputs
module alu_control_unit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] F,
    input  logic [2:0] P,
    output logic [2:0] C,
    output logic       illegal
);

    logic [2:0] c_d;
    logic [2:0] c_q;
    logic       illegal_d;
    logic       illegal_q;

    alu_funct_decode u_decode (
        .F            (F),
        .P            (P),
        .c_next       (c_d),
        .illegal_next (illegal_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q       <= ALU_000;
            illegal_q <= 1'b0;
        end else begin
            c_q       <= c_d;
            illegal_q <= illegal_d;
        end
    end

    assign C       = c_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - self-checking bench for alu_control_unit
module tb_alu_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] F;
    logic [2:0] P;
    logic [2:0] C;
    logic       illegal;

    int total;
    int bad;

    typedef struct {
        string      name;
        logic [5:0] f;
        logic [2:0] p;
        logic [2:0] c;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    // Reference: R-type legal function codes indexed by F[2:0] (F[5:3] must be zero).
    logic [2:0] rsel[8];
    bit         rok[8];

    alu_control_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .F       (F),
        .P       (P),
        .C       (C),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_out(input logic [5:0] f, input logic [2:0] p);
        if (p != 3'd7) return {1'b0, p};
        if (f > 6'd7 || !rok[f[2:0]]) return 4'b1000;
        return {1'b0, rsel[f[2:0]]};
    endfunction

    task automatic check(input string name, input logic [2:0] exp_c, input logic exp_ill);
        total++;
        if (C !== exp_c || illegal !== exp_ill) begin
            bad++;
            $display("FAIL %s: got C=%b illegal=%b, expected C=%b illegal=%b",
                     name, C, illegal, exp_c, exp_ill);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] r;
        logic [5:0] rf;
        logic [2:0] rp;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 8; i++) begin
            rok[i]  = 1'b0;
            rsel[i] = 3'b000;
        end
        rok[2] = 1'b1; rsel[2] = 3'd5;
        rok[3] = 1'b1; rsel[3] = 3'd6;
        rok[4] = 1'b1; rsel[4] = 3'd0;
        rok[5] = 1'b1; rsel[5] = 3'd1;
        rok[7] = 1'b1; rsel[7] = 3'd4;

        vecs.push_back('{"rtype_02", 6'b000010, 3'b111, 3'b101, 1'b0});
        vecs.push_back('{"rtype_03", 6'b000011, 3'b111, 3'b110, 1'b0});
        vecs.push_back('{"rtype_04", 6'b000100, 3'b111, 3'b000, 1'b0});
        vecs.push_back('{"rtype_05", 6'b000101, 3'b111, 3'b001, 1'b0});
        vecs.push_back('{"rtype_07", 6'b000111, 3'b111, 3'b100, 1'b0});
        vecs.push_back('{"pass_000", 6'b001000, 3'b000, 3'b000, 1'b0});
        vecs.push_back('{"pass_001", 6'b001010, 3'b001, 3'b001, 1'b0});
        vecs.push_back('{"pass_010", 6'b001000, 3'b010, 3'b010, 1'b0});
        vecs.push_back('{"pass_011", 6'b001010, 3'b011, 3'b011, 1'b0});
        vecs.push_back('{"pass_100", 6'b001000, 3'b100, 3'b100, 1'b0});
        vecs.push_back('{"pass_101", 6'b001010, 3'b101, 3'b101, 1'b0});
        vecs.push_back('{"pass_110", 6'b001000, 3'b110, 3'b110, 1'b0});
        vecs.push_back('{"ill_000000", 6'b000000, 3'b111, 3'b000, 1'b1});
        vecs.push_back('{"ill_000001", 6'b000001, 3'b111, 3'b000, 1'b1});
        vecs.push_back('{"ill_000110", 6'b000110, 3'b111, 3'b000, 1'b1});
        vecs.push_back('{"ill_001010", 6'b001010, 3'b111, 3'b000, 1'b1});
        vecs.push_back('{"ill_100010", 6'b100010, 3'b111, 3'b000, 1'b1});
        vecs.push_back('{"ill_clear", 6'b000000, 3'b010, 3'b010, 1'b0});

        // Reset held while clocking with a legal R-type input.
        rst_n = 1'b0;
        P     = 3'b111;
        F     = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 3'b000, 1'b0);
        end
        rst_n = 1'b1;
        check("reset_release_pre_edge", 3'b000, 1'b0);
        tick();
        check("reset_release_first_edge", 3'b101, 1'b0);

        foreach (vecs[i]) begin
            F = vecs[i].f;
            P = vecs[i].p;
            tick();
            check(vecs[i].name, vecs[i].c, vecs[i].ill);
        end

        // Latency: inputs change just after an edge, output waits for the next one.
        F = 6'b000011;
        P = 3'b111;
        tick();
        check("latency_setup", 3'b110, 1'b0);
        F = 6'b000111;
        #3;
        check("latency_hold", 3'b110, 1'b0);
        tick();
        check("latency_update", 3'b100, 1'b0);

        // Async reset between edges during an R-type stream.
        F = 6'b000101;
        tick();
        check("stream_before_reset", 3'b001, 1'b0);
        F = 6'b000010;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 3'b000, 1'b0);
        tick();
        check("async_reset_held", 3'b000, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check("async_reset_recover", 3'b101, 1'b0);

        // Async reset also clears a pending illegal flag.
        F = 6'b000000;
        tick();
        check("illegal_before_reset", 3'b000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears_illegal", 3'b000, 1'b0);
        #2;
        rst_n = 1'b1;

        // Randomized stream against the reference model.
        for (int i = 0; i < 300; i++) begin
            rp = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
            F  = rf;
            P  = rp;
            tick();
            r = ref_out(rf, rp);
            check($sformatf("random_%0d_P%b_F%b", i, rp, rf), r[2:0], r[3]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
